// File: rtl/bcd_down_timer.sv
// Two-digit BCD down-counting timer with IDLE/RUN/HOLD/EXPIRED control.
// Counts a loaded value down to 00 on tick strobes and pulses done at terminal count.
module bcd_down_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    input  logic       reload_en,
    output logic [7:0] count,
    output logic       running,
    output logic       done,
    output logic       zero
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_EXPIRED
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_count;
    logic [7:0] w_count_next;
    logic [7:0] r_reload;
    logic [7:0] w_reload_next;
    logic       r_done;
    logic       w_done_next;
    logic       r_running;

    logic [3:0] w_load_tens;
    logic [3:0] w_load_ones;
    logic [7:0] w_load_clean;
    logic [7:0] w_count_dec;
    logic       w_zero;
    logic       w_terminal;

    // Out-of-range digits clamp to 9 so the count never holds a non-BCD digit.
    assign w_load_tens  = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
    assign w_load_ones  = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
    assign w_load_clean = {w_load_tens, w_load_ones};

    assign w_count_dec = (r_count[3:0] != 4'd0) ? {r_count[7:4], r_count[3:0] - 4'd1}
                                                : {r_count[7:4] - 4'd1, 4'd9};

    assign w_zero     = (r_count == 8'h00);
    assign w_terminal = (r_count == 8'h01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_reload  <= w_reload_next;
            r_done    <= w_done_next;
            r_running <= (w_state_next == ST_RUN);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_reload_next = r_reload;
        w_done_next   = 1'b0;

        if (load) begin
            w_count_next  = w_load_clean;
            w_reload_next = w_load_clean;
            w_state_next  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!pause && start && !w_zero) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        w_state_next = ST_HOLD;
                    end else if (tick) begin
                        if (w_terminal) begin
                            w_done_next = 1'b1;
                            if (reload_en) begin
                                w_count_next = r_reload;
                            end else begin
                                w_count_next = '0;
                                w_state_next = ST_EXPIRED;
                            end
                        end else if (!w_zero) begin
                            w_count_next = w_count_dec;
                        end
                    end
                end
                ST_HOLD: begin
                    if (start && !pause) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    // Restart from the reload value; an empty reload has nothing to run.
                    if (start) begin
                        w_count_next = r_reload;
                        w_state_next = (r_reload == 8'h00) ? ST_IDLE : ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign done    = r_done;
    assign zero    = w_zero;

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Two-digit BCD (00–99) down-counting timer with a start/pause/expire control state machine.
- Complements the team's free-running decade up-counter: it counts down from a loaded value to 00, then signals expiry.
- Sits beside the up-counter in the timing subsystem.
- Consumes a prescaled `tick` enable and drives a done pulse to the sequencer.

Parameters:
- None. Widths are fixed: 2 BCD digits, 8 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- load  input  1  load `load_val` into the count and reload registers.
- load_val  input  8  BCD value: [7:4] tens, [3:0] ones.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- tick  input  1  count-enable strobe; one decrement per cycle in which it is high.
- reload_en  input  1  on expiry, reload from the reload register and keep running.
- count  output  8  current BCD count.
- running  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse on terminal count.
- zero  output  1  combinational; high when count == 8'h00.

Behaviour:
- Reset: state=IDLE, count=8'h00, reload_reg=8'h00, done=0, running=0.
- Load sanitising: any digit of `load_val` greater than 9 is clamped to 9. Example: 8'hA3→8'h93, 8'h4F→8'h49.
- Priority, per edge: reset > load > pause > start > tick.
- load (any state):
  - count <= sanitised value; reload_reg <= sanitised value.
  - state <= IDLE; done <= 0.
- States: IDLE, RUN, HOLD, EXPIRED. `running` = (state==RUN), registered.
- IDLE:
  - start & count!=0 → RUN.
  - start & count==0 → stay in IDLE, no done pulse.
  - tick is ignored.
- RUN:
  - pause → HOLD; no decrement that cycle, even if tick=1.
  - tick & count>01 → BCD decrement:
    - ones!=0: ones-1.
    - ones==0: ones=9 and tens-1.
    - Example: 8'h40→8'h39, 8'h10→8'h09.
  - tick & count==01 (terminal):
    - done=1 for exactly the next cycle.
    - reload_en=1: count <= reload_reg, stay in RUN.
    - reload_en=0: count <= 8'h00, state <= EXPIRED.
  - start with no pause: no effect.
- HOLD:
  - count is frozen; tick is ignored.
  - start & !pause → RUN.
  - start & pause → stay in HOLD.
- EXPIRED:
  - count holds 00.
  - start → count <= reload_reg and RUN; if reload_reg==0, go to IDLE instead.
  - tick and pause are ignored.
- done rules:
  - Registered; asserts on the same edge that count leaves 01.
  - Never high for two consecutive cycles unless reload_reg==01 with tick held high. Each terminal event is one pulse.
- Asynchronous reset mid-RUN: all outputs return to reset values immediately, with no pending done.
- Invariant: count never holds a non-BCD digit in any state.
- Decrement latency: count updates on the edge where tick was sampled high; there is no extra pipeline stage.

Test Plan:
- Reset, then load 8'h12, start, tick continuously → count 12,11,10,09…01,00. done high for 1 cycle with count=00, state EXPIRED, running=0.
- Load 8'hA3 → count=8'h93. Load 8'hFF → count=8'h99.
- Load 8'h03, reload_en=1, start, tick every cycle → count 03,02,01,03,02…; done pulses every 3rd tick; running stays 1.
- Load 8'h20, start, 3 ticks (count 17), assert pause together with tick → count stays 17, state HOLD. 5 further ticks → still 17. start → RUN, next tick → 16.
- Load 8'h00, start → stays IDLE, done=0. Then load 8'h05, start, assert reset asynchronously mid-count → count=00, running=0, done=0 before the next clock edge.
- In EXPIRED (from reload_reg 8'h02), start → count=02, RUN. Two ticks → done pulse, EXPIRED again.
